uart_game_cmd_rx: RTL

UART 8N1 receiver plus command decoder that drives the Pong game-control inputs from a serial host. It replaces the button-chord game-start path and can also drive the paddle inputs. It sits directly upstream of the Pong top, in the divided 25 MHz pixel-clock domain. Its outputs are active-high. They go either straight to the Pong top, or are ORed with the debounced switch levels after inversion, since the board buttons are active-low.

---
 rtl/uart_game_cmd_rx.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_game_cmd_rx.sv
// UART 8N1 receiver with a single-byte command decoder that drives the Pong
// game-start pulse and the four paddle levels, all in the pixel-clock domain.
module uart_game_cmd_rx #(
  parameter int CLKS_PER_BIT = 217,
  parameter int HOLD_CLKS    = 250000
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_RX_Serial,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  output logic       o_Frame_Err,
  output logic       o_Game_Start,
  output logic       o_Paddle_Up_P1,
  output logic       o_Paddle_Dn_P1,
  output logic       o_Paddle_Up_P2,
  output logic       o_Paddle_Dn_P2
);

  localparam int              TW        = (HOLD_CLKS > 1) ? $clog2(HOLD_CLKS) : 1;
  localparam logic [15:0]     BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0]     HALF_BIT  = 16'((CLKS_PER_BIT - 1) / 2);
  localparam logic [TW-1:0]   HOLD_LAST = TW'(HOLD_CLKS - 1);

  typedef enum logic [2:0] {
    S_ARM, S_IDLE, S_START, S_DATA, S_STOP, S_BREAK
  } state_e;

  // ---------------------------------------------------------------------------
  // Line synchronizer: both flops reset high so reset looks like an idle line.
  // ---------------------------------------------------------------------------
  logic meta_q, line_q;

  // NOTE: every flop here has an async reset, but only control state needs a
  // defined value; the data shadow is reset too because it is tiny.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      meta_q <= 1'b1;
      line_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignment makes the two stages sample the old
      // values, giving a real two-flop chain instead of one collapsed flop.
      meta_q <= i_RX_Serial;
      line_q <= meta_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shadow_q, shadow_d;
  logic [7:0]  byte_q, byte_d;
  logic        dv_q, dv_d;
  logic        ferr_q, ferr_d;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q  <= S_ARM;
      cnt_q    <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      byte_q   <= '0;
      dv_q     <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      byte_q   <= byte_d;
      dv_q     <= dv_d;
      ferr_q   <= ferr_d;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latch).
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    byte_d   = byte_q;
    dv_d     = 1'b0;
    ferr_d   = 1'b0;

    case (state_q)
      S_ARM: begin
        if (!line_q) begin
          cnt_d = '0;
        end else if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_IDLE: begin
        if (!line_q) begin
          cnt_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_q == HALF_BIT) begin
          cnt_d = '0;
          if (!line_q) begin
            idx_d   = '0;
            state_d = S_DATA;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d            = '0;
          shadow_d[idx_q]  = line_q;
          if (idx_q == 3'd7) state_d = S_STOP;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (line_q) begin
            byte_d  = shadow_q;
            dv_d    = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_BREAK: begin
        if (line_q) state_d = S_IDLE;
      end
      default: state_d = S_ARM;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Command decoder and per-player paddle hold timers
  // ---------------------------------------------------------------------------
  logic          game_q, game_d;
  logic          up1_q, up1_d, dn1_q, dn1_d;
  logic          up2_q, up2_d, dn2_q, dn2_d;
  logic [TW-1:0] tmr1_q, tmr1_d, tmr2_q, tmr2_d;
  logic [7:0]    cmd;

  // Clearing bit 5 folds lower-case letters onto upper case.
  assign cmd = byte_q & 8'hDF;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      game_q <= 1'b0;
      up1_q  <= 1'b0;
      dn1_q  <= 1'b0;
      up2_q  <= 1'b0;
      dn2_q  <= 1'b0;
      tmr1_q <= '0;
      tmr2_q <= '0;
    end else begin
      game_q <= game_d;
      up1_q  <= up1_d;
      dn1_q  <= dn1_d;
      up2_q  <= up2_d;
      dn2_q  <= dn2_d;
      tmr1_q <= tmr1_d;
      tmr2_q <= tmr2_d;
    end
  end

  always_comb begin
    game_d = 1'b0;
    up1_d  = up1_q;
    dn1_d  = dn1_q;
    up2_d  = up2_q;
    dn2_d  = dn2_q;
    tmr1_d = tmr1_q;
    tmr2_d = tmr2_q;

    if (up1_q || dn1_q) begin
      if (tmr1_q == '0) begin
        up1_d = 1'b0;
        dn1_d = 1'b0;
      end else begin
        tmr1_d = tmr1_q - TW'(1);
      end
    end
    if (up2_q || dn2_q) begin
      if (tmr2_q == '0) begin
        up2_d = 1'b0;
        dn2_d = 1'b0;
      end else begin
        tmr2_d = tmr2_q - TW'(1);
      end
    end

    // A fresh command overrides the timer bookkeeping above.
    if (dv_q) begin
      if (byte_q == 8'h20) begin
        up1_d  = 1'b0;
        dn1_d  = 1'b0;
        up2_d  = 1'b0;
        dn2_d  = 1'b0;
        tmr1_d = '0;
        tmr2_d = '0;
      end else begin
        case (cmd)
          8'h47: game_d = 1'b1;
          8'h51: begin up1_d = 1'b1; dn1_d = 1'b0; tmr1_d = HOLD_LAST; end
          8'h41: begin up1_d = 1'b0; dn1_d = 1'b1; tmr1_d = HOLD_LAST; end
          8'h50: begin up2_d = 1'b1; dn2_d = 1'b0; tmr2_d = HOLD_LAST; end
          8'h4C: begin up2_d = 1'b0; dn2_d = 1'b1; tmr2_d = HOLD_LAST; end
          default: ;
        endcase
      end
    end
  end

  assign o_RX_DV        = dv_q;
  assign o_RX_Byte      = byte_q;
  assign o_Frame_Err    = ferr_q;
  assign o_Game_Start   = game_q;
  assign o_Paddle_Up_P1 = up1_q;
  assign o_Paddle_Dn_P1 = dn1_q;
  assign o_Paddle_Up_P2 = up2_q;
  assign o_Paddle_Dn_P2 = dn2_q;

endmodule
